seq_detector_stream_ctrl: RTL and testbench

Controller that feeds a byte stream, one bit per clock, through a programmable Moore sequence detector and counts matches until a programmed target is reached. It latches the pattern configuration and accepts bytes over a valid/ready handshake. It serialises each byte MSB-first into the detector core and reports per-match pulses, a running count and a completion strobe. It sits between a byte-oriented source and the serial detector datapath, so the detector is reusable for any pattern up to PAT_MAX bits.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/seq_detector_prog_moore.sv | 59 +++++
 rtl/seq_detector_stream_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seq_detector_stream_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, constants and helpers for the streaming sequence detector.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        DONE
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    // Lengths of 0, 1 or anything past the history depth fall back to the full depth.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int pat_max);
        logic [3:0] res;
        if (len < 4'd2 || int'(len) > pat_max) begin
            res = 4'(pat_max);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_prog_moore.sv
// Programmable Moore detector: serial bit history, fill counter and registered-state match.
module seq_detector_prog_moore
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               bit_en,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [3:0]         len,
    input  logic               overlap,
    output logic               match
);

    localparam int FILL_W = $clog2(PAT_MAX + 1);

    logic [PAT_MAX-1:0] history;
    logic [PAT_MAX-1:0] mask;
    logic [FILL_W-1:0]  fill;
    logic               fresh;
    logic               hit;

    // The comparison stays true until the next shift, so fresh limits match to one cycle.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        hit   = (((history ^ pattern) & mask) == '0) && (int'(fill) >= int'(len));
        match = hit && fresh;
    end

    // After a non-overlapping hit the incoming bit starts a new window of one bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history <= '0;
            fill    <= '0;
            fresh   <= 1'b0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
            fresh   <= 1'b0;
        end else begin
            fresh <= bit_en;
            if (bit_en) begin
                history <= {history[PAT_MAX-2:0], bit_in};
                if (hit && !overlap) begin
                    fill <= FILL_W'(1);
                end else if (int'(fill) < PAT_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_detector_stream_ctrl.sv
// Byte-stream controller around the programmable Moore detector with match counting.
// Optional sticky match flag (match_clr / match_seen) built when SEQ_DET_CTRL_STICKY_EN is defined.
module seq_detector_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done
`ifdef SEQ_DET_CTRL_STICKY_EN
    ,
    input  logic               match_clr,
    output logic               match_seen
`endif
);

    localparam int BIT_W = $clog2(BYTE_W);

    state_t             state;
    state_t             state_next;
    logic [PAT_MAX-1:0] pat_q;
    logic [3:0]         len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [BYTE_W-1:0]  shreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               load_cfg;
    logic               take_byte;
    logic               bit_en;
    logic               det_clear;

    seq_detector_prog_moore #(
        .PAT_MAX (PAT_MAX)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .clear   (det_clear),
        .bit_en  (bit_en),
        .bit_in  (shreg[BYTE_W-1]),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (overlap_q),
        .match   (match)
    );

    // The CHECK decision looks at the count including the final bit's match.
    always_comb begin
        cnt_next   = (match && match_count != '1) ? match_count + 1'b1 : match_count;
        state_next = state;
        byte_ready = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        load_cfg   = 1'b0;
        det_clear  = 1'b0;
        take_byte  = 1'b0;
        bit_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load_cfg   = 1'b1;
                    det_clear  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (byte_valid) begin
                    take_byte  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    bit_en = 1'b1;
                    if (bit_cnt == BIT_W'(BYTE_W - 1)) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (target_q != '0 && cnt_next >= target_q) begin
                    state_next = DONE;
                end else begin
                    state_next = LOAD;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The count is frozen in IDLE so a run's result survives abort and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
        end else begin
            state <= state_next;
            if (load_cfg) begin
                pat_q       <= cfg_pattern;
                len_q       <= clamp_len(cfg_len, PAT_MAX);
                overlap_q   <= cfg_overlap;
                target_q    <= cfg_target;
                match_count <= '0;
            end else if (state != IDLE) begin
                match_count <= cnt_next;
            end
            if (take_byte) begin
                shreg   <= byte_in;
                bit_cnt <= '0;
            end else if (bit_en) begin
                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_DET_CTRL_STICKY_EN
    // A match in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_seen <= 1'b0;
        end else if (match) begin
            match_seen <= 1'b1;
        end else if (match_clr || load_cfg) begin
            match_seen <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_stream_ctrl.sv
// Directed self-checking bench for seq_detector_stream_ctrl.
module tb_seq_detector_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       done;
`ifdef SEQ_DET_CTRL_STICKY_EN
    logic       match_clr = 1'b0;
    logic       match_seen;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  mv;
    logic [19:0] rv20;
    logic [19:0] mv20;

    seq_detector_stream_ctrl #(
        .PAT_MAX (8),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done)
`ifdef SEQ_DET_CTRL_STICKY_EN
        ,
        .match_clr   (match_clr),
        .match_seen  (match_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Programs the configuration and starts a run from IDLE; leaves the DUT in LOAD.
    task automatic apply_stimulus(input logic [7:0] pat, input logic [3:0] len,
                                  input logic ov, input logic [7:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_target  = tgt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Hands one byte over from LOAD and records match after each bit; ends in CHECK.
    task automatic run_byte(input logic [7:0] b, output logic [7:0] mvec);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        mvec = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mvec[i] = match;
        end
    endtask

    task automatic go_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy",  32'(busy), 32'd0);
        check_output("reset_ready", 32'(byte_ready), 32'd0);
        check_output("reset_match", 32'(match), 32'd0);
        check_output("reset_count", 32'(match_count), 32'd0);
        check_output("reset_done",  32'(done), 32'd0);
        rst = 1'b1;
        tick();

        $display("[TB] overlapping 11011 on 0xDB");
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd0);
        check_output("t1_ready", 32'(byte_ready), 32'd1);
        check_output("t1_busy",  32'(busy), 32'd1);
        run_byte(8'hDB, mv);
        check_output("t1_matches", 32'(mv), 32'h90);
        check_output("t1_count_in_check", 32'(match_count), 32'd1);
        tick();
        check_output("t1_count", 32'(match_count), 32'd2);
        check_output("t1_ready_again", 32'(byte_ready), 32'd1);
        go_idle();
        check_output("t1_idle", 32'(busy), 32'd0);

        $display("[TB] non-overlapping 11011 on 0xDB");
        apply_stimulus(8'h1B, 4'd5, 1'b0, 8'd0);
        run_byte(8'hDB, mv);
        check_output("t2_matches", 32'(mv), 32'h10);
        tick();
        check_output("t2_count", 32'(match_count), 32'd1);
        go_idle();

        $display("[TB] target 2 reached at end of byte");
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd2);
        run_byte(8'hDB, mv);
        check_output("t3_done_low_in_check", 32'(done), 32'd0);
        tick();
        check_output("t3_done",  32'(done), 32'd1);
        check_output("t3_busy",  32'(busy), 32'd1);
        check_output("t3_ready", 32'(byte_ready), 32'd0);
        check_output("t3_count", 32'(match_count), 32'd2);
        tick();
        check_output("t3_done_pulse", 32'(done), 32'd0);
        check_output("t3_idle",       32'(busy), 32'd0);
        check_output("t3_count_hold", 32'(match_count), 32'd2);

        $display("[TB] match spanning byte boundary, valid held high");
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd0);
        byte_in    = 8'h03;
        byte_valid = 1'b1;
        rv20 = '0;
        mv20 = '0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t == 0) byte_in = 8'h60;
            rv20[t] = byte_ready;
            mv20[t] = match;
        end
        byte_valid = 1'b0;
        check_output("t4_ready_pattern", 32'(rv20), 32'h80200);
        check_output("t4_match_pattern", 32'(mv20), 32'h02000);
        check_output("t4_count", 32'(match_count), 32'd1);
        go_idle();

        $display("[TB] abort during SHIFT");
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd0);
        run_byte(8'hDB, mv);
        tick();
        check_output("t5_count_before", 32'(match_count), 32'd2);
        byte_in    = 8'hDB;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t5_busy",  32'(busy), 32'd0);
        check_output("t5_ready", 32'(byte_ready), 32'd0);
        check_output("t5_done",  32'(done), 32'd0);
        check_output("t5_count", 32'(match_count), 32'd2);
        tick();
        check_output("t5_done_later", 32'(done), 32'd0);

        $display("[TB] reset mid-SHIFT");
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd0);
        run_byte(8'hDB, mv);
        tick();
        byte_in    = 8'hDB;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check_output("t6_busy",  32'(busy), 32'd0);
        check_output("t6_ready", 32'(byte_ready), 32'd0);
        check_output("t6_match", 32'(match), 32'd0);
        check_output("t6_count", 32'(match_count), 32'd0);
        check_output("t6_done",  32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        apply_stimulus(8'h1B, 4'd5, 1'b1, 8'd0);
        run_byte(8'h1B, mv);
        check_output("t6_matches_after", 32'(mv), 32'h80);
        tick();
        check_output("t6_count_after", 32'(match_count), 32'd1);
        go_idle();

        $display("[TB] out-of-range length uses full depth");
        apply_stimulus(8'hDB, 4'd0, 1'b1, 8'd0);
        run_byte(8'hDB, mv);
        check_output("t7_matches", 32'(mv), 32'h80);
        tick();
        check_output("t7_count", 32'(match_count), 32'd1);
`ifdef SEQ_DET_CTRL_STICKY_EN
        check_output("t7_seen", 32'(match_seen), 32'd1);
        match_clr = 1'b1;
        tick();
        match_clr = 1'b0;
        check_output("t7_seen_clr", 32'(match_seen), 32'd0);
`endif
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
